// File: rtl/uart_tx_buffer_pkg.sv
// ============================================================================
// Module   : uart_tx_buffer_pkg
// Purpose  : Shared UART configuration constants, including the transmit
//            buffer default geometry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_buffer_pkg;

    // Line configuration shared by the UART blocks
    localparam int c_UART_CLK_FREQ_HZ  = 50_000_000;
    localparam int c_UART_BAUD_RATE    = 115_200;
    localparam int c_UART_CLKS_PER_BIT = c_UART_CLK_FREQ_HZ / c_UART_BAUD_RATE;
    localparam int c_UART_DATA_BITS    = 8;

    // Transmit buffer defaults
    localparam int c_TX_BUF_DEPTH      = 16;
    localparam int c_TX_BUF_DATA_WIDTH = c_UART_DATA_BITS;

endpackage : uart_tx_buffer_pkg

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
// ============================================================================
// Module   : uart_tx_buffer
// Purpose  : First-word-fall-through character FIFO between the register
//            interface and the UART transmitter, with registered fill level,
//            low-watermark crossing pulse and dropped-write pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int   DEPTH      = c_TX_BUF_DEPTH,
    parameter int   DATA_WIDTH = c_TX_BUF_DATA_WIDTH,
    localparam int  LOG_DEPTH  = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [LOG_DEPTH:0]    level_o,
    input  logic [LOG_DEPTH:0]    thresh_i,
    output logic                  thresh_irq_o,
    output logic                  overflow_o
);

    // Storage is deliberately left out of reset; the head is only meaningful
    // while pop_valid_o is high.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [LOG_DEPTH:0]    r_wr_ptr;
    logic [LOG_DEPTH:0]    r_rd_ptr;
    logic [LOG_DEPTH:0]    r_level;
    logic                  r_thresh_irq;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [LOG_DEPTH:0]    w_wr_ptr_nxt;
    logic [LOG_DEPTH:0]    w_rd_ptr_nxt;
    logic [LOG_DEPTH:0]    w_level_nxt;
    logic                  w_cross;

    // Occupancy decode, handshakes and next-state pointer arithmetic
    always_comb begin
        w_full       = (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]) &&
                       (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]);
        w_empty      = (r_wr_ptr == r_rd_ptr);
        // A full buffer refuses writes even when a pop frees a slot this cycle
        w_push       = push_valid_i && !w_full;
        w_pop        = pop_ready_i && !w_empty;
        w_wr_ptr_nxt = r_wr_ptr + {{LOG_DEPTH{1'b0}}, w_push};
        w_rd_ptr_nxt = r_rd_ptr + {{LOG_DEPTH{1'b0}}, w_pop};
        // Modulo-2*DEPTH difference yields 0..DEPTH
        w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
        // Downward crossing of the watermark only; staying below is silent
        w_cross      = (r_level > thresh_i) && (w_level_nxt <= thresh_i);
    end

    // Pointer and level registers; flush wins over any handshake
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
        end
    end

    // Single-cycle event pulses; a flush suppresses both
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_thresh_irq <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_thresh_irq <= !clr_i && w_cross;
            r_overflow   <= !clr_i && push_valid_i && w_full;
        end
    end

    // Character storage write port
    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i) begin
            r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= push_data_i;
        end
    end

    assign push_ready_o = !w_full;
    assign pop_valid_o  = !w_empty;
    assign pop_data_o   = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];
    assign level_o      = r_level;
    assign thresh_irq_o = r_thresh_irq;
    assign overflow_o   = r_overflow;

endmodule : uart_tx_buffer

`default_nettype wire
